// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
//   Shared constants and helpers for the board I/O blocks (button conditioning
//   and the LED blink/sequencer blocks).
//   - DEFAULT_CLK_FREQ : board clock in Hz, default for every timing parameter.
//   - MS_TO_CYCLES     : converts a duration in milliseconds to clock cycles.
// -----------------------------------------------------------------------------
package board_io_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 25_000_000;

  // Divide first so that large clock frequencies do not overflow 32 bits.
  function automatic int unsigned MS_TO_CYCLES(input int unsigned freq,
                                               input int unsigned ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   Conditions one raw push-button pin: 2-flop synchroniser, polarity fix,
//   stability counter, debounced level and registered press/release pulses.
//   With BUTTON_DEBOUNCER_LONG_PRESS_EN defined, a hold counter also produces a
//   one-cycle long-press pulse LONG_CYCLES cycles after the press pulse.
// Ports:
//   clk        in  clock, all logic on posedge
//   rst        in  synchronous reset, active-high
//   raw        in  asynchronous pin level
//   state      out debounced level, 1 = pressed
//   press      out 1-cycle pulse when state rises
//   rel        out 1-cycle pulse when state falls
//   long_pulse out 1-cycle long-press pulse (0 when macro undefined)
// -----------------------------------------------------------------------------
module debounce_channel #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES   = 10,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // Pin level that means "not pressed"; the synchroniser resets to it so
  // that leaving reset never looks like an edge.
  localparam logic IDLE_PIN = ACTIVE_LOW;

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("debounce_channel: STABLE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("debounce_channel: LONG_CYCLES must be >= 1");
  end

  logic             sync1_q, sync2_q;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = s;
      cnt_d   = '0;
      press_d = s;
      rel_d   = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state = state_q;
  assign press = press_q;
  assign rel   = rel_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Saturating at HOLD_MAX guarantees a single pulse per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!state_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == HOLD_MAX - HOLD_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditions N_BUTTONS raw push-button pins into clean debounced levels plus
//   one-cycle press / release (and optional long-press) pulses per channel.
//   Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN (long-press pulses).
// Ports:
//   clk          in  single clock, posedge
//   rst          in  synchronous reset, active-high
//   btn_raw      in  [N_BUTTONS] asynchronous raw pin levels
//   btn_state    out [N_BUTTONS] debounced level, 1 = pressed
//   btn_press    out [N_BUTTONS] 1-cycle pulse on press
//   btn_release  out [N_BUTTONS] 1-cycle pulse on release
//   btn_long     out [N_BUTTONS] 1-cycle long-press pulse (0 without macro)
// -----------------------------------------------------------------------------
module button_debouncer
  import board_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned N_BUTTONS   = 4,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_state,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_long
);

  localparam int unsigned STABLE_CYCLES = MS_TO_CYCLES(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES   = MS_TO_CYCLES(CLK_FREQ, LONG_MS);

  if (N_BUTTONS < 1 || N_BUTTONS > 16) begin : g_bad_n
    $error("button_debouncer: N_BUTTONS must be 1..16");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW != 0)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .state      (btn_state[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i]),
      .long_pulse (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int N      = 4;
  localparam int STABLE = 4;   // 1000 Hz * 4 ms
  localparam int LONG   = 10;  // 1000 Hz * 10 ms

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = 4'hF;
  logic [N-1:0] btn_state, btn_press, btn_release, btn_long;

  button_debouncer #(
    .CLK_FREQ    (1000),
    .N_BUTTONS   (N),
    .DEBOUNCE_MS (4),
    .ACTIVE_LOW  (1),
    .LONG_MS     (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pin samples reach the filter two edges late; the level
  // flips once STABLE consecutive samples disagree with it.
  int           t = 0;
  bit           dly[N][$];
  bit           st[N];
  int           last_agree[N];
  int           press_t[N];
  logic [N-1:0] exp_state = '0, exp_press = '0, exp_rel = '0, exp_long = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s t=%0d actual=%0h expected=%0h", tag, t, act, exp);
    end
  endtask

  task automatic model_edge(input bit r);
    bit samp;
    t++;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        dly[i].delete();
        dly[i].push_back(1'b0);
        dly[i].push_back(1'b0);
        st[i]         = 1'b0;
        last_agree[i] = t;
        press_t[i]    = t;
      end else begin
        samp = dly[i].pop_front();
        dly[i].push_back(~btn_raw[i]);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        if (st[i] && (t - press_t[i] == LONG)) exp_long[i] = 1'b1;
`endif
        if (samp == st[i]) begin
          last_agree[i] = t;
        end else if (t - last_agree[i] >= STABLE) begin
          st[i]         = samp;
          last_agree[i] = t;
          if (samp) begin
            exp_press[i] = 1'b1;
            press_t[i]   = t;
          end else begin
            exp_rel[i] = 1'b1;
          end
        end
      end
      exp_state[i] = st[i];
    end
  endtask

  // One clock: drive rst, take the edge, update the model, compare #1 later.
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk("state",   32'(btn_state),   32'(exp_state));
    chk("press",   32'(btn_press),   32'(exp_press));
    chk("release", 32'(btn_release), 32'(exp_rel));
    chk("long",    32'(btn_long),    32'(exp_long));
    chk("press_release_excl", 32'(btn_press & btn_release), 32'(0));
  endtask

  int n_press;
  int n_long;
  int press_k;

  initial begin
    // 1. Reset with pins idle, then idle running: everything stays 0.
    btn_raw = 4'hF;
    for (int k = 0; k < 3; k++) step(1'b1);
    chk("reset_state", 32'(btn_state), 32'(0));
    for (int k = 0; k < 6; k++) step(1'b0);
    chk("idle_state", 32'(btn_state), 32'(0));

    // 2. Channel 0 pressed and held: level rises exactly 6 cycles later.
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0);
      if (k == 5) chk("lat_before", 32'(btn_state[0]), 32'(0));
      if (k == 6) begin
        chk("lat_state", 32'(btn_state[0]), 32'(1));
        chk("lat_press", 32'(btn_press[0]), 32'(1));
      end
    end
    step(1'b0);
    chk("press_one_cycle", 32'(btn_press[0]), 32'(0));

    // 3. Channel 1 low for only 3 cycles: filtered out.
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0);
    btn_raw[1] = 1'b1;
    n_press = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      n_press += int'(btn_press[1]);
    end
    chk("glitch_state", 32'(btn_state[1]), 32'(0));
    chk("glitch_pulses", 32'(n_press), 32'(0));

    // 4. Channel 2 bounces 0,1,0,1 then settles low: one press, 6 cycles in.
    for (int k = 0; k < 4; k++) begin
      btn_raw[2] = k[0];
      step(1'b0);
    end
    btn_raw[2] = 1'b0;
    n_press = 0;
    press_k = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0);
      if (btn_press[2]) begin
        n_press++;
        press_k = k;
      end
    end
    chk("bounce_presses", 32'(n_press), 32'(1));
    chk("bounce_press_at", 32'(press_k), 32'(6));

    // 5. Release everything, then press all four in the same cycle.
    btn_raw = 4'hF;
    for (int k = 0; k < 10; k++) step(1'b0);
    btn_raw = 4'h0;
    for (int k = 1; k <= 6; k++) step(1'b0);
    chk("all_press", 32'(btn_press), 32'(4'hF));
    for (int k = 0; k < 4; k++) step(1'b0);
    btn_raw = 4'hF;
    for (int k = 1; k <= 6; k++) step(1'b0);
    chk("all_release", 32'(btn_release), 32'(4'hF));
    step(1'b0);
    chk("all_release_once", 32'(btn_release), 32'(0));

    // 6. Reset mid-hold with the pin still low, then re-press detection.
    btn_raw = 4'hE;
    for (int k = 0; k < 8; k++) step(1'b0);
    step(1'b1);
    chk("rst_state", 32'(btn_state), 32'(0));
    for (int k = 1; k <= 6; k++) begin
      step(1'b0);
      if (k == 5) chk("repress_before", 32'(btn_state[0]), 32'(0));
    end
    chk("repress", 32'(btn_press[0]), 32'(1));
    n_long = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0);
      n_long += int'(btn_long[0]);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      if (k == LONG) chk("long_at", 32'(btn_long[0]), 32'(1));
`endif
    end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    chk("long_once", 32'(n_long), 32'(1));
`else
    chk("long_off", 32'(n_long), 32'(0));
`endif
    btn_raw = 4'hF;
    for (int k = 0; k < 8; k++) step(1'b0);

    // Random bouncing on all channels with occasional resets.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
      end
      step($urandom_range(199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
